// File: rtl/vram_write_scheduler_if.sv
// Request/response bundle for the video-memory write scheduler: CPU pixel writes,
// fill commands, and the registered write-port outputs.
interface vram_write_scheduler_if #(
  parameter int COL_W   = 7,
  parameter int ROW_W   = 6,
  parameter int COLOR_W = 3
);
  logic                     iCpuWrite;
  logic [COL_W-1:0]         iCpuCol;
  logic [ROW_W-1:0]         iCpuRow;
  logic [COLOR_W-1:0]       iCpuColor;
  logic                     iFillStart;
  logic [COL_W-1:0]         iFillX0;
  logic [COL_W-1:0]         iFillX1;
  logic [ROW_W-1:0]         iFillY0;
  logic [ROW_W-1:0]         iFillY1;
  logic [COLOR_W-1:0]       iFillColor;
  logic                     oWriteEnable;
  logic [COL_W+ROW_W-1:0]   oWriteAddress;
  logic [COLOR_W-1:0]       oDataIn;
  logic                     oFillBusy;
  logic                     oFillDone;

  modport master (
    output iCpuWrite, iCpuCol, iCpuRow, iCpuColor,
    output iFillStart, iFillX0, iFillX1, iFillY0, iFillY1, iFillColor,
    input  oWriteEnable, oWriteAddress, oDataIn, oFillBusy, oFillDone
  );

  modport slave (
    input  iCpuWrite, iCpuCol, iCpuRow, iCpuColor,
    input  iFillStart, iFillX0, iFillX1, iFillY0, iFillY1, iFillColor,
    output oWriteEnable, oWriteAddress, oDataIn, oFillBusy, oFillDone
  );
endinterface

// File: rtl/vram_write_scheduler.sv
// Arbitrates the single VRAM write port between CPU pixel writes (priority) and a
// rectangle-fill engine. Optional power-on clear: define VRAM_CLEAR_ON_RESET_EN.
module vram_write_scheduler #(
  parameter int COLS    = 80,
  parameter int ROWS    = 60,
  parameter int COL_W   = 7,
  parameter int ROW_W   = 6,
  parameter int COLOR_W = 3,
  parameter logic [COLOR_W-1:0] CLEAR_COLOR = 3'b000
) (
  input  logic                  Clock,
  input  logic                  Reset,
  vram_write_scheduler_if.slave bus
);

  localparam logic [COL_W-1:0] COL_LIMIT = COL_W'(COLS);
  localparam logic [ROW_W-1:0] ROW_LIMIT = ROW_W'(ROWS);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t               state, stateNext;
  logic [COL_W-1:0]     x0, x1, curCol;
  logic [ROW_W-1:0]     y0, y1, curRow;
  logic [COLOR_W-1:0]   fillColor;
  logic                 loadBounds, advance, clearPending;
  logic [COL_W-1:0]     ldX0, ldX1;
  logic [ROW_W-1:0]     ldY0, ldY1;
  logic [COLOR_W-1:0]   ldColor;

  logic                   wrEn_p1;
  logic [COL_W+ROW_W-1:0] wrAddr_p1;
  logic [COLOR_W-1:0]     wrData_p1;

`ifdef VRAM_CLEAR_ON_RESET_EN
  // Armed by reset; consumed by the first IDLE cycle after release.
  always_ff @(posedge Clock) begin
    if (!Reset)
      clearPending <= 1'b1;
    else if (state == IDLE)
      clearPending <= 1'b0;
  end
`else
  assign clearPending = 1'b0;
`endif

  always_ff @(posedge Clock) begin
    if (!Reset)
      state <= IDLE;
    else
      state <= stateNext;
  end

  always_comb begin
    stateNext  = state;
    loadBounds = 1'b0;
    advance    = 1'b0;
    ldX0       = bus.iFillX0;
    ldX1       = bus.iFillX1;
    ldY0       = bus.iFillY0;
    ldY1       = bus.iFillY1;
    ldColor    = bus.iFillColor;
    case (state)
      IDLE: begin
        if (clearPending) begin
          loadBounds = 1'b1;
          ldX0       = '0;
          ldX1       = COL_LAST;
          ldY0       = '0;
          ldY1       = ROW_LAST;
          ldColor    = CLEAR_COLOR;
          stateNext  = FILL;
        end else if (bus.iFillStart) begin
          loadBounds = 1'b1;
          stateNext  = (bus.iFillX0 > bus.iFillX1 || bus.iFillY0 > bus.iFillY1) ? DONE : FILL;
        end
      end
      FILL: begin
        // A CPU write stalls the cursor for this cycle.
        if (!bus.iCpuWrite) begin
          advance = 1'b1;
          if (curCol == x1 && curRow == y1)
            stateNext = DONE;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (loadBounds) begin
      x0        <= ldX0;
      x1        <= ldX1;
      y0        <= ldY0;
      y1        <= ldY1;
      fillColor <= ldColor;
    end
  end

  // Cursor walks row-major; equality against x1 wraps it before any overflow.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      curCol <= '0;
      curRow <= '0;
    end else if (loadBounds) begin
      curCol <= ldX0;
      curRow <= ldY0;
    end else if (advance) begin
      if (curCol == x1) begin
        curCol <= x0;
        curRow <= curRow + ROW_W'(1);
      end else begin
        curCol <= curCol + COL_W'(1);
      end
    end
  end

  // Stage p1: registered write port.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      wrEn_p1   <= 1'b0;
      wrAddr_p1 <= '0;
      wrData_p1 <= '0;
    end else if (bus.iCpuWrite) begin
      wrEn_p1   <= 1'b1;
      wrAddr_p1 <= {bus.iCpuCol, bus.iCpuRow};
      wrData_p1 <= bus.iCpuColor;
    end else if (advance) begin
      wrEn_p1   <= (curCol < COL_LIMIT) && (curRow < ROW_LIMIT);
      wrAddr_p1 <= {curCol, curRow};
      wrData_p1 <= fillColor;
    end else begin
      wrEn_p1   <= 1'b0;
    end
  end

  assign bus.oWriteEnable  = wrEn_p1;
  assign bus.oWriteAddress = wrAddr_p1;
  assign bus.oDataIn       = wrData_p1;
  assign bus.oFillBusy     = (state != IDLE);
  assign bus.oFillDone     = (state == DONE);

endmodule

// File: tb/tb_vram_write_scheduler.sv
// Directed bench for vram_write_scheduler: fills, CPU priority, clipping, empty
// rectangles, reset abort and start-while-busy.
module tb_vram_write_scheduler;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  int   testsRun = 0;
  int   testsFailed = 0;
  int   weCount;

  vram_write_scheduler_if #(.COL_W(7), .ROW_W(6), .COLOR_W(3)) bus ();

  vram_write_scheduler dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  task automatic checkVal(input string tag, input int got, input int exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  function automatic int mkAddr(input int c, input int r);
    return c * 64 + r;
  endfunction

  task automatic checkPort(input string tag, input int we, input int addr, input int data);
    checkVal({tag, "_we"}, int'(bus.oWriteEnable), we);
    if (we != 0) begin
      checkVal({tag, "_addr"}, int'(bus.oWriteAddress), addr);
      checkVal({tag, "_data"}, int'(bus.oDataIn), data);
    end
  endtask

  task automatic startFill(input int fx0, input int fy0, input int fx1, input int fy1, input int color);
    bus.iFillStart = 1'b1;
    bus.iFillX0    = 7'(fx0);
    bus.iFillX1    = 7'(fx1);
    bus.iFillY0    = 6'(fy0);
    bus.iFillY1    = 6'(fy1);
    bus.iFillColor = 3'(color);
    tick();
    bus.iFillStart = 1'b0;
  endtask

`ifdef VRAM_CLEAR_ON_RESET_EN
  task automatic waitClear();
    int n = 0;
    bit seenDone = 0;
    for (int i = 0; i < 6000 && !seenDone; i++) begin
      tick();
      if (bus.oWriteEnable && bus.oDataIn == 3'b000) n++;
      if (bus.oFillDone) seenDone = 1;
    end
    checkVal("clear_writes", n, 4800);
    checkVal("clear_done", int'(seenDone), 1);
    tick();
  endtask
`endif

  initial begin
    bus.iCpuWrite  = 1'b0;
    bus.iCpuCol    = '0;
    bus.iCpuRow    = '0;
    bus.iCpuColor  = '0;
    bus.iFillStart = 1'b0;
    bus.iFillX0    = '0;
    bus.iFillX1    = '0;
    bus.iFillY0    = '0;
    bus.iFillY1    = '0;
    bus.iFillColor = '0;

    tick();
    tick();
    checkVal("rst_we", int'(bus.oWriteEnable), 0);
    checkVal("rst_addr", int'(bus.oWriteAddress), 0);
    checkVal("rst_data", int'(bus.oDataIn), 0);
    checkVal("rst_busy", int'(bus.oFillBusy), 0);
    checkVal("rst_done", int'(bus.oFillDone), 0);
    Reset = 1'b1;
`ifdef VRAM_CLEAR_ON_RESET_EN
    waitClear();
`else
    tick();
`endif

    // Single-row fill.
    startFill(2, 3, 4, 3, 5);
    checkVal("t1_busy0", int'(bus.oFillBusy), 1);
    checkVal("t1_we0", int'(bus.oWriteEnable), 0);
    tick();
    checkPort("t1_p0", 1, mkAddr(2, 3), 5);
    checkVal("t1_done_p0", int'(bus.oFillDone), 0);
    tick();
    checkPort("t1_p1", 1, mkAddr(3, 3), 5);
    tick();
    checkPort("t1_p2", 1, mkAddr(4, 3), 5);
    checkVal("t1_done", int'(bus.oFillDone), 1);
    checkVal("t1_busy3", int'(bus.oFillBusy), 1);
    tick();
    checkVal("t1_busy_end", int'(bus.oFillBusy), 0);
    checkVal("t1_done_end", int'(bus.oFillDone), 0);
    checkVal("t1_we_end", int'(bus.oWriteEnable), 0);
    checkVal("t1_addr_hold", int'(bus.oWriteAddress), mkAddr(4, 3));

    // CPU write preempts the fill by one cycle.
    startFill(0, 0, 1, 1, 7);
    weCount = 0;
    bus.iCpuWrite = 1'b1;
    bus.iCpuCol   = 7'd10;
    bus.iCpuRow   = 6'd10;
    bus.iCpuColor = 3'd2;
    tick();
    bus.iCpuWrite = 1'b0;
    checkPort("t2_cpu", 1, mkAddr(10, 10), 2);
    weCount += int'(bus.oWriteEnable);
    tick(); checkPort("t2_p0", 1, mkAddr(0, 0), 7); weCount += int'(bus.oWriteEnable);
    tick(); checkPort("t2_p1", 1, mkAddr(1, 0), 7); weCount += int'(bus.oWriteEnable);
    tick(); checkPort("t2_p2", 1, mkAddr(0, 1), 7); weCount += int'(bus.oWriteEnable);
    tick(); checkPort("t2_p3", 1, mkAddr(1, 1), 7); weCount += int'(bus.oWriteEnable);
    checkVal("t2_done", int'(bus.oFillDone), 1);
    tick(); weCount += int'(bus.oWriteEnable);
    checkVal("t2_we_total", weCount, 5);

    // Clipping at the right and bottom edges.
    startFill(78, 59, 81, 60, 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) checkPort("t3_p0", 1, mkAddr(78, 59), 1);
      else if (i == 1) checkPort("t3_p1", 1, mkAddr(79, 59), 1);
      else checkVal("t3_clip_we", int'(bus.oWriteEnable), 0);
      checkVal("t3_done", int'(bus.oFillDone), (i == 7) ? 1 : 0);
    end
    tick();
    checkVal("t3_busy_end", int'(bus.oFillBusy), 0);

    // Empty rectangle.
    startFill(5, 0, 4, 0, 3);
    checkVal("t4_done", int'(bus.oFillDone), 1);
    checkVal("t4_busy", int'(bus.oFillBusy), 1);
    checkVal("t4_we", int'(bus.oWriteEnable), 0);
    tick();
    checkVal("t4_done_end", int'(bus.oFillDone), 0);
    checkVal("t4_we_end", int'(bus.oWriteEnable), 0);

    // Reset mid-fill aborts without a done pulse.
    startFill(0, 0, 3, 3, 6);
    tick(); tick(); tick();
    checkPort("t5_p2", 1, mkAddr(2, 0), 6);
    Reset = 1'b0;
    tick();
    checkVal("t5_rst_we", int'(bus.oWriteEnable), 0);
    checkVal("t5_rst_addr", int'(bus.oWriteAddress), 0);
    checkVal("t5_rst_data", int'(bus.oDataIn), 0);
    checkVal("t5_rst_busy", int'(bus.oFillBusy), 0);
    checkVal("t5_rst_done", int'(bus.oFillDone), 0);
    Reset = 1'b1;
`ifdef VRAM_CLEAR_ON_RESET_EN
    waitClear();
`else
    tick();
    checkVal("t5_no_done", int'(bus.oFillDone), 0);
    tick();
    checkVal("t5_idle", int'(bus.oFillBusy), 0);
`endif
    startFill(10, 20, 11, 20, 3);
    tick();
    checkPort("t5_new0", 1, mkAddr(10, 20), 3);
    tick();
    checkPort("t5_new1", 1, mkAddr(11, 20), 3);
    checkVal("t5_new_done", int'(bus.oFillDone), 1);
    tick();

    // Start while busy is dropped, not queued.
    startFill(0, 0, 1, 0, 4);
    bus.iFillStart = 1'b1;
    bus.iFillX0 = 7'd20; bus.iFillX1 = 7'd30;
    bus.iFillY0 = 6'd20; bus.iFillY1 = 6'd30;
    bus.iFillColor = 3'd1;
    tick();
    bus.iFillStart = 1'b0;
    checkPort("t6_p0", 1, mkAddr(0, 0), 4);
    tick();
    checkPort("t6_p1", 1, mkAddr(1, 0), 4);
    checkVal("t6_done", int'(bus.oFillDone), 1);
    tick();
    checkVal("t6_busy_end", int'(bus.oFillBusy), 0);
    checkVal("t6_we_end", int'(bus.oWriteEnable), 0);
    tick();
    checkVal("t6_no_queue", int'(bus.oFillBusy), 0);
    checkVal("t6_no_queue_we", int'(bus.oWriteEnable), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
